// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and a decode helper.
package alu_pkg;

  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } op_t;

  // True for the five encodings the ALU implements.
  function automatic logic op_defined(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU. One shared adder: op[2] selects subtraction,
// which also drives SLT. The overflow flag always reflects that adder,
// so undefined encodings still report add (op[2]=0) or subtract overflow.
module alu
  import alu_pkg::*;
(
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] out,
  output logic          zero,
  output logic          of
);

  logic [DW-1:0] b_eff;
  logic [DW-1:0] sum;

  // Shared add/subtract path and signed overflow.
  always_comb begin
    b_eff = op[2] ? ~b : b;
    sum   = a + b_eff + {{(DW-1){1'b0}}, op[2]};
    of    = (a[DW-1] == b_eff[DW-1]) && (sum[DW-1] != a[DW-1]);
  end

  // Result select; undefined encodings produce zero.
  always_comb begin
    case (op)
      OP_AND:         out = a & b;
      OP_OR:          out = a | b;
      OP_ADD, OP_SUB: out = sum;
      OP_SLT:         out = {{(DW-1){1'b0}}, sum[DW-1] ^ of};
      default:        out = '0;
    endcase
    zero = (out == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters. A single
// result register returns each result to its owner via valid/ready; a
// consume and a new grant may coincide for one op per cycle.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0][2:0]      req_op,
  input  logic [NREQ-1:0][DW-1:0]   req_a,
  input  logic [NREQ-1:0][DW-1:0]   req_b,
  output logic [NREQ-1:0]           resp_valid,
  input  logic [NREQ-1:0]           resp_ready,
  output logic [DW-1:0]             resp_out,
  output logic                      resp_zero,
  output logic                      resp_of,
  output logic                      resp_err
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  own_q, own_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [DW-1:0]   out_q, out_d;
  logic            zero_q, zero_d;
  logic            of_q, of_d;
  logic            err_q, err_d;

  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  logic            slot_free;
  logic            consume;
  logic            grant;

  logic [2:0]      alu_op;
  logic [DW-1:0]   alu_a, alu_b, alu_out;
  logic            alu_zero, alu_of;

  // Round-robin pick: first valid requester scanning upward from last+1.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_q) + k) % NREQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Slot availability, grant qualification and handshake outputs.
  always_comb begin
    consume   = (state_q == S_FULL) && resp_ready[own_q];
    // Held low in reset so no request is acknowledged while the block is reset.
    slot_free = rst_n && ((state_q == S_EMPTY) || consume);
    grant     = slot_free && grant_any;
    req_ready = '0;
    if (grant) req_ready[grant_idx] = 1'b1;
    resp_valid = '0;
    if (state_q == S_FULL) resp_valid[own_q] = 1'b1;
  end

  // Operand mux feeding the shared ALU from the granted requester.
  always_comb begin
    alu_op = req_op[grant_idx];
    alu_a  = req_a[grant_idx];
    alu_b  = req_b[grant_idx];
  end

  alu u_alu (
    .op   (alu_op),
    .a    (alu_a),
    .b    (alu_b),
    .out  (alu_out),
    .zero (alu_zero),
    .of   (alu_of)
  );

  // Next-state: capture on grant, free the slot on a consume without grant.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    out_d   = out_q;
    zero_d  = zero_q;
    of_d    = of_q;
    err_d   = err_q;
    if (grant) begin
      state_d = S_FULL;
      own_d   = grant_idx;
      last_d  = grant_idx;
      out_d   = alu_out;
      zero_d  = alu_zero;
      of_d    = alu_of;
      err_d   = !op_defined(alu_op);
    end else if (consume) begin
      state_d = S_EMPTY;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= S_EMPTY;
      own_q   <= '0;
      last_q  <= IDW'(NREQ - 1);
      out_q   <= '0;
      zero_q  <= 1'b0;
      of_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      of_q    <= of_d;
      err_q   <= err_d;
    end
  end

  assign resp_out  = out_q;
  assign resp_zero = zero_q;
  assign resp_of   = of_q;
  assign resp_err  = err_q;

endmodule
